// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch/PC stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int IA_WIDTH_DEF  = 8;
    localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/fetch_pc_unit_retire_counter.sv
// rtl/fetch_pc_unit_retire_counter.sv - saturating retired-instruction counter with clear
module retire_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and IDLE/RUN/HALTED fetch sequencer
// Optional retired-instruction counter enabled by FETCH_RETIRE_CNT_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int IA_WIDTH  = IA_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [IA_WIDTH-1:0]  start_addr_i,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 jump_en_i,
    input  logic                 branch_taken_i,
    input  logic [IA_WIDTH-1:0]  destination_i,
    output logic [IA_WIDTH-1:0]  pc_o,
`ifdef FETCH_RETIRE_CNT_EN
    output logic [CNT_WIDTH-1:0] retired_o,
`endif
    output logic                 fetch_valid_o,
    output logic                 done_o
);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [IA_WIDTH-1:0] r_pc;
    logic [IA_WIDTH-1:0] w_next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            RUN: begin
                // Stall outranks everything, halt outranks any redirect.
                if (!stall_i) begin
                    if (halt_i) begin
                        w_next_state = HALTED;
                    end else if (jump_en_i || branch_taken_i) begin
                        w_next_pc = destination_i;
                    end else begin
                        w_next_pc = r_pc + IA_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (start_i) begin
                    w_next_state = RUN;
                    w_next_pc    = start_addr_i;
                end
            end
        endcase
    end

    assign pc_o          = r_pc;
    assign fetch_valid_o = (r_state == RUN) && !stall_i;
    assign done_o        = (r_state == HALTED);

`ifdef FETCH_RETIRE_CNT_EN
    logic w_start_accept;
    logic w_retire_en;

    assign w_start_accept = start_i && (r_state != RUN);
    assign w_retire_en    = fetch_valid_o && !halt_i;

    retire_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_retire_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_start_accept),
        .i_en    (w_retire_en),
        .o_count (retired_o)
    );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed plus randomized checks of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] start_addr_i;
    logic       stall_i;
    logic       halt_i;
    logic       jump_en_i;
    logic       branch_taken_i;
    logic [7:0] destination_i;
    logic [7:0] pc_o;
    logic       fetch_valid_o;
    logic       done_o;
`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0] retired_o;
`endif

    int tests = 0;
    int fails = 0;

    // Model: program status as two flags, PC as an integer, counter as integer.
    bit m_running;
    bit m_halted;
    int m_pc;
    int m_ret;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .start_addr_i   (start_addr_i),
        .stall_i        (stall_i),
        .halt_i         (halt_i),
        .jump_en_i      (jump_en_i),
        .branch_taken_i (branch_taken_i),
        .destination_i  (destination_i),
        .pc_o           (pc_o),
`ifdef FETCH_RETIRE_CNT_EN
        .retired_o      (retired_o),
`endif
        .fetch_valid_o  (fetch_valid_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":pc"}, {24'd0, pc_o}, m_pc);
        chk({tag, ":done"}, {31'd0, done_o}, {31'd0, m_halted});
        chk({tag, ":valid"}, {31'd0, fetch_valid_o}, {31'd0, m_running && !stall_i});
`ifdef FETCH_RETIRE_CNT_EN
        chk({tag, ":ret"}, {16'd0, retired_o}, m_ret);
`endif
    endtask

    task automatic model_reset();
        m_running = 0;
        m_halted  = 0;
        m_pc      = 0;
        m_ret     = 0;
    endtask

    task automatic drive(input bit st, input int sa, input bit sl, input bit h,
                         input bit j, input bit b, input int d);
        start_i        = st;
        start_addr_i   = sa[7:0];
        stall_i        = sl;
        halt_i         = h;
        jump_en_i      = j;
        branch_taken_i = b;
        destination_i  = d[7:0];
    endtask

    // One clock: check combinational valid with current inputs, advance model, check after edge.
    task automatic step(input string tag);
        #1;
        chk({tag, ":pre_valid"}, {31'd0, fetch_valid_o}, {31'd0, m_running && !stall_i});
        @(posedge clk);
        if (m_running) begin
            if (!stall_i) begin
                if (halt_i) begin
                    m_running = 0;
                    m_halted  = 1;
                end else begin
                    if (m_ret < 65535) m_ret++;
                    if (jump_en_i || branch_taken_i) m_pc = destination_i;
                    else m_pc = (m_pc + 1) % 256;
                end
            end
        end else if (start_i) begin
            m_running = 1;
            m_halted  = 0;
            m_pc      = start_addr_i;
            m_ret     = 0;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset = 1'b0;

        drive(1, 3, 0, 0, 0, 0, 0); step("start3");
        chk("start3_pc", {24'd0, pc_o}, 3);
        drive(0, 0, 0, 0, 0, 0, 0); step("seq4");
        chk("seq4_pc", {24'd0, pc_o}, 4);
        step("seq5");
        step("seq6");
        chk("seq6_pc", {24'd0, pc_o}, 6);
        step("seq7");

        drive(0, 0, 0, 0, 1, 0, 2); step("jump2");
        chk("jump2_pc", {24'd0, pc_o}, 2);
        drive(0, 0, 0, 0, 0, 0, 0); step("after_jump");
        chk("after_jump_pc", {24'd0, pc_o}, 3);

        drive(0, 0, 0, 0, 1, 0, 9); step("to9");
        drive(0, 0, 1, 0, 0, 1, 14); step("stall1");
        step("stall2");
        chk("stall_hold_pc", {24'd0, pc_o}, 9);
        drive(0, 0, 0, 0, 0, 1, 14); step("branch14");
        chk("branch14_pc", {24'd0, pc_o}, 14);

        drive(0, 0, 0, 0, 1, 1, 255); step("to255");
        drive(0, 0, 0, 0, 0, 0, 0); step("wrap");
        chk("wrap_pc", {24'd0, pc_o}, 0);
        chk("wrap_valid", {31'd0, fetch_valid_o}, 1);

        drive(0, 0, 0, 0, 1, 0, 20); step("to20");
        drive(1, 9, 0, 1, 1, 0, 33); step("halt_jump");
        chk("halt_done", {31'd0, done_o}, 1);
        chk("halt_pc", {24'd0, pc_o}, 20);
        drive(1, 5, 0, 0, 0, 0, 0); step("restart5");
        chk("restart_done", {31'd0, done_o}, 0);
        chk("restart_pc", {24'd0, pc_o}, 5);

        drive(0, 0, 0, 0, 1, 0, 40); step("to40");
        drive(0, 0, 0, 0, 1, 0, 77);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0); step("cnt_start");
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step("cnt_run");
        chk("cnt_pc", {24'd0, pc_o}, 4);
`ifdef FETCH_RETIRE_CNT_EN
        chk("cnt_ret4", {16'd0, retired_o}, 4);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) == 0, $urandom, ($urandom % 5) == 0,
                  ($urandom % 25) == 0, ($urandom % 6) == 0,
                  ($urandom % 6) == 0, $urandom);
            if (($urandom % 97) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                chk_all("rand_reset");
                @(negedge clk);
                reset = 1'b0;
            end else begin
                step("rand");
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage for the 12-bit processor. It sits directly downstream of the jump destination calculator: it consumes the jump enable and destination address produced there, plus the resolved branch condition, and drives the instruction address into instruction memory. It owns the run/halt state machine that starts a program, sequences it, and reports completion.

## Interface
- `IA_WIDTH`, 8, instruction address width in bits.
- `CNT_WIDTH`, 16, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start pulse; honored only in IDLE or HALTED.
- `start_addr_i`  in  IA_WIDTH  address loaded into the PC on an accepted start.
- `stall_i`  in  1  downstream stall; holds the PC and suppresses all other updates except reset.
- `halt_i`  in  1  the current instruction is a halt.
- `jump_en_i`  in  1  unconditional redirect from the jump destination calculator.
- `branch_taken_i`  in  1  branch condition resolved true for the current instruction.
- `destination_i`  in  IA_WIDTH  redirect target for both jumps and taken branches.
- `pc_o`  out  IA_WIDTH  registered instruction address.
- `fetch_valid_o`  out  1  `pc_o` addresses a live instruction this cycle.
- `done_o`  out  1  high while in HALTED.
- `retired_o`  out  CNT_WIDTH  retired-instruction count; present only with the macro.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- IDLE:
  - `start_i` → PC = `start_addr_i`, go to RUN.
  - Otherwise hold.
- RUN, priority per cycle, highest first:
  1. `stall_i` → hold PC and state.
  2. `halt_i` → go to HALTED; PC holds.
  3. `jump_en_i | branch_taken_i` → PC = `destination_i`.
  4. Otherwise PC = PC + 1.
- In RUN, `start_i` is ignored.
- HALTED:
  - `done_o` = 1.
  - `start_i` → PC = `start_addr_i`, go to RUN. This is a restart without reset.
- PC arithmetic:
  - Increment is unsigned modulo 2^IA_WIDTH, so 255 + 1 → 0.
  - No overflow flag is produced.
  - Wrap is legal and not an error.
- `jump_en_i` and `branch_taken_i` together: a single redirect to `destination_i`. There is no double-count.
- Redirect and halt together: halt wins; the PC does not change.
- `fetch_valid_o` = (state == RUN) & ~`stall_i`. It is combinational from state and stall.
- Reset mid-operation: all state is cleared immediately (asynchronous). Any redirect in flight is discarded.

## Timing
- Reset values:
  - `pc_o` = 0.
  - state = IDLE.
  - `fetch_valid_o` = 0.
  - `done_o` = 0.
  - `retired_o` = 0.
- Start: `start_i` sampled at edge N → `pc_o` = `start_addr_i` and state = RUN visible after edge N. `fetch_valid_o` rises in cycle N+1.
- Redirect latency is one cycle: inputs sampled at edge N → the new `pc_o` is visible after edge N.
- Halt: sampled at edge N → `done_o` high and `fetch_valid_o` low after edge N.
- Stall is level-sensitive, with no skid. Deasserting it resumes on the next edge using that cycle's inputs.
- Redirect inputs are don't-care outside RUN.

## Configuration
- Macro: `FETCH_RETIRE_CNT_EN`.
- Defined:
  - `retired_o` exists.
  - The counter increments on each RUN cycle with `fetch_valid_o` = 1 and `halt_i` = 0.
  - It saturates at all-ones; there is no wrap.
  - It clears on reset and on an accepted `start_i`.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, RUN, HALTED).
  - `IA_WIDTH_DEF` = 8.
  - `CNT_WIDTH_DEF` = 16.
- Optional sub-module `retire_counter`: saturating counter with clear and enable, instantiated only under `FETCH_RETIRE_CNT_EN`.
- PC register and state machine stay in the top module.

## Test plan
- Reset then `start_i` with `start_addr_i` = 8'd3, no other events → `pc_o` sequence 3, 4, 5, 6; `fetch_valid_o` = 1 from the cycle after start.
- In RUN at PC 7, `jump_en_i` = 1 with `destination_i` = 8'd2 → next `pc_o` = 2, then 3.
- At PC 9, `branch_taken_i` = 1 with `destination_i` = 8'd14, `stall_i` = 1 for 2 cycles → PC holds at 9 while stalled. Once the stall drops, with `branch_taken_i` still high, `pc_o` = 14.
- PC at 8'd255, no redirect → `pc_o` = 0 next cycle, still RUN.
- `halt_i` together with `jump_en_i` at PC 20 → `done_o` = 1 and `pc_o` stays 20. A following `start_i` with addr 8'd5 → RUN at 5, `done_o` = 0.
- Reset asserted mid-RUN at PC 40 → `pc_o` = 0 and state IDLE without waiting for a clock edge. With `FETCH_RETIRE_CNT_EN`, `retired_o` = 0, and it counts 4 after 4 unstalled RUN cycles.
